// File: rtl/ct_had_tap_pkg.sv
// Shared TAP state encoding and instruction constants for the HAD JTAG TAP.
// Define HAD_TAP_IDCODE_EN to build with the IDCODE register and IDCODE as the reset instruction.
package ct_had_tap_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SHF_DR = 4'd4,
        EX1_DR = 4'd5,
        PAU_DR = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SHF_IR = 4'd11,
        EX1_IR = 4'd12,
        PAU_IR = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_e;

    localparam logic [7:0]  INSTR_IDCODE   = 8'h01;
    localparam logic [7:0]  INSTR_BYPASS   = 8'hFF;
    localparam logic [7:0]  IR_CAPTURE     = 8'h01;
    localparam logic [31:0] IDCODE_DEFAULT = 32'h1000_0B6F;

`ifdef HAD_TAP_IDCODE_EN
    localparam logic [7:0]  INSTR_RESET    = INSTR_IDCODE;
`else
    localparam logic [7:0]  INSTR_RESET    = INSTR_BYPASS;
`endif

endpackage

// File: rtl/ct_had_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine: state register plus TMS-driven next-state logic.
module ct_had_tap_fsm
    import ct_had_tap_pkg::*;
(
    input  logic       tclk,
    input  logic       trst,
    input  logic       tms,
    input  logic       tap_en,
    output logic [3:0] state_r,
    output logic [3:0] next_state_s
);

    tap_state_e cur_r;
    tap_state_e nxt_s;

    // Standard TAP transition table; a disabled TAP is parked in TLR.
    always_comb begin
        nxt_s = TLR;
        if (!tap_en) begin
            nxt_s = TLR;
        end else begin
            case (cur_r)
                TLR:     nxt_s = tms ? TLR    : RTI;
                RTI:     nxt_s = tms ? SEL_DR : RTI;
                SEL_DR:  nxt_s = tms ? SEL_IR : CAP_DR;
                CAP_DR:  nxt_s = tms ? EX1_DR : SHF_DR;
                SHF_DR:  nxt_s = tms ? EX1_DR : SHF_DR;
                EX1_DR:  nxt_s = tms ? UPD_DR : PAU_DR;
                PAU_DR:  nxt_s = tms ? EX2_DR : PAU_DR;
                EX2_DR:  nxt_s = tms ? UPD_DR : SHF_DR;
                UPD_DR:  nxt_s = tms ? SEL_DR : RTI;
                SEL_IR:  nxt_s = tms ? TLR    : CAP_IR;
                CAP_IR:  nxt_s = tms ? EX1_IR : SHF_IR;
                SHF_IR:  nxt_s = tms ? EX1_IR : SHF_IR;
                EX1_IR:  nxt_s = tms ? UPD_IR : PAU_IR;
                PAU_IR:  nxt_s = tms ? EX2_IR : PAU_IR;
                EX2_IR:  nxt_s = tms ? UPD_IR : SHF_IR;
                UPD_IR:  nxt_s = tms ? SEL_DR : RTI;
                default: nxt_s = TLR;
            endcase
        end
    end

    // State register with synchronous reset into TLR.
    always_ff @(posedge tclk) begin
        if (trst) begin
            cur_r <= TLR;
        end else begin
            cur_r <= nxt_s;
        end
    end

    assign state_r      = cur_r;
    assign next_state_s = nxt_s;

endmodule

// File: rtl/ct_had_tap_ctrl.sv
// HAD JTAG TAP: instruction register, BYPASS/IDCODE data registers, external-DR strobes and TDO mux.
// The IDCODE register exists only when HAD_TAP_IDCODE_EN is defined; otherwise 8'h01 decodes as BYPASS.
module ct_had_tap_ctrl
    import ct_had_tap_pkg::*;
#(
    parameter logic [31:0] IDCODE_VAL = IDCODE_DEFAULT
) (
    input  logic       tclk,
    input  logic       trst,
    input  logic       pad_had_jtg_tms,
    input  logic       io_serial_tdi,
    input  logic       io_sm_tap_en,
    input  logic       ext_dr_tdo,
    output logic       sm_io_tdo_en,
    output logic       sm_serial_tdo,
    output logic [7:0] sm_ir_value,
    output logic       sm_dr_capture,
    output logic       sm_dr_shift,
    output logic       sm_dr_update,
    output logic       sm_ir_update,
    output logic       sm_tlr
);

    logic [3:0] state_s;
    logic [3:0] next_state_s;
    logic [7:0] ir_shift_r;
    logic       bypass_r;
    logic       idcode_sel_s;
    logic       bypass_sel_s;
    logic       ext_sel_s;
    logic       dr_tdo_s;

    ct_had_tap_fsm u_fsm (
        .tclk         (tclk),
        .trst         (trst),
        .tms          (pad_had_jtg_tms),
        .tap_en       (io_sm_tap_en),
        .state_r      (state_s),
        .next_state_s (next_state_s)
    );

    // Instruction decode into the three data-register paths.
    always_comb begin
`ifdef HAD_TAP_IDCODE_EN
        idcode_sel_s = (sm_ir_value == INSTR_IDCODE);
        bypass_sel_s = (sm_ir_value == INSTR_BYPASS);
`else
        idcode_sel_s = 1'b0;
        bypass_sel_s = (sm_ir_value == INSTR_BYPASS) || (sm_ir_value == INSTR_IDCODE);
`endif
        ext_sel_s    = !idcode_sel_s && !bypass_sel_s;
    end

    // IR shift stage and the active instruction; odd-length shifts are loaded as-is.
    always_ff @(posedge tclk) begin
        if (trst) begin
            ir_shift_r  <= 8'h00;
            sm_ir_value <= INSTR_RESET;
        end else begin
            case (state_s)
                CAP_IR:  ir_shift_r <= IR_CAPTURE;
                SHF_IR:  ir_shift_r <= {io_serial_tdi, ir_shift_r[7:1]};
                default: ir_shift_r <= ir_shift_r;
            endcase
            if (state_s == TLR) begin
                sm_ir_value <= INSTR_RESET;
            end else if (state_s == UPD_IR) begin
                sm_ir_value <= ir_shift_r;
            end else begin
                sm_ir_value <= sm_ir_value;
            end
        end
    end

    // One-bit bypass register.
    always_ff @(posedge tclk) begin
        if (trst) begin
            bypass_r <= 1'b0;
        end else if (bypass_sel_s && (state_s == CAP_DR)) begin
            bypass_r <= 1'b0;
        end else if (bypass_sel_s && (state_s == SHF_DR)) begin
            bypass_r <= io_serial_tdi;
        end else begin
            bypass_r <= bypass_r;
        end
    end

`ifdef HAD_TAP_IDCODE_EN
    logic [31:0] idcode_r;

    // IDCODE register: capture the constant, shift out LSB first.
    always_ff @(posedge tclk) begin
        if (trst) begin
            idcode_r <= 32'h0000_0000;
        end else if (idcode_sel_s && (state_s == CAP_DR)) begin
            idcode_r <= IDCODE_VAL;
        end else if (idcode_sel_s && (state_s == SHF_DR)) begin
            idcode_r <= {io_serial_tdi, idcode_r[31:1]};
        end else begin
            idcode_r <= idcode_r;
        end
    end
`else
    logic unused_idcode_s;
    assign unused_idcode_s = ^IDCODE_VAL;
`endif

    // Strobes and TDO enable are flopped from the next state so they line up with the state itself.
    always_ff @(posedge tclk) begin
        if (trst) begin
            sm_io_tdo_en  <= 1'b0;
            sm_dr_capture <= 1'b0;
            sm_dr_shift   <= 1'b0;
            sm_dr_update  <= 1'b0;
            sm_ir_update  <= 1'b0;
            sm_tlr        <= 1'b1;
        end else begin
            sm_io_tdo_en  <= (next_state_s == SHF_IR) || (next_state_s == SHF_DR);
            sm_dr_capture <= ext_sel_s && (next_state_s == CAP_DR);
            sm_dr_shift   <= ext_sel_s && (next_state_s == SHF_DR);
            sm_dr_update  <= ext_sel_s && (next_state_s == UPD_DR);
            sm_ir_update  <= (next_state_s == UPD_IR);
            sm_tlr        <= (next_state_s == TLR);
        end
    end

    // TDO source selection.
    always_comb begin
        dr_tdo_s = ext_dr_tdo;
        if (bypass_sel_s) begin
            dr_tdo_s = bypass_r;
`ifdef HAD_TAP_IDCODE_EN
        end else if (idcode_sel_s) begin
            dr_tdo_s = idcode_r[0];
`endif
        end else begin
            dr_tdo_s = ext_dr_tdo;
        end
        case (state_s)
            SHF_IR:  sm_serial_tdo = ir_shift_r[0];
            SHF_DR:  sm_serial_tdo = dr_tdo_s;
            default: sm_serial_tdo = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ct_had_tap_ctrl.sv
// Self-checking bench for ct_had_tap_ctrl; expectations come from a scan-level model of IR/DR contents.
module tb_ct_had_tap_ctrl;

    logic       tclk = 1'b0;
    logic       trst, tms, tdi, tap_en, ext_tdo;
    logic       tdo_en, tdo, dr_cap, dr_shf, dr_upd, ir_upd, tlr;
    logic [7:0] ir_value;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef HAD_TAP_IDCODE_EN
    localparam bit         IDC    = 1'b1;
    localparam logic [7:0] RST_IR = 8'h01;
`else
    localparam bit         IDC    = 1'b0;
    localparam logic [7:0] RST_IR = 8'hFF;
`endif
    localparam logic [31:0] IDV = 32'h1000_0B6F;

    logic [7:0] model_ir;

    ct_had_tap_ctrl #(.IDCODE_VAL(IDV)) dut (
        .tclk            (tclk),
        .trst            (trst),
        .pad_had_jtg_tms (tms),
        .io_serial_tdi   (tdi),
        .io_sm_tap_en    (tap_en),
        .ext_dr_tdo      (ext_tdo),
        .sm_io_tdo_en    (tdo_en),
        .sm_serial_tdo   (tdo),
        .sm_ir_value     (ir_value),
        .sm_dr_capture   (dr_cap),
        .sm_dr_shift     (dr_shf),
        .sm_dr_update    (dr_upd),
        .sm_ir_update    (ir_upd),
        .sm_tlr          (tlr)
    );

    always #5 tclk = ~tclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tclk);
        #1;
    endtask

    // 0 = external DR, 1 = bypass, 2 = IDCODE
    function automatic int dr_kind(input logic [7:0] ir);
        if (ir == 8'hFF) return 1;
        if (ir == 8'h01) return IDC ? 2 : 1;
        return 0;
    endfunction

    task automatic reset_tap();
        trst = 1'b1;
        tick(1'b0, 1'b0);
        trst = 1'b0;
        check("rst_tlr", tlr, 1'b1);
        check("rst_ir", ir_value, RST_IR);
        check("rst_tdo_en", tdo_en, 1'b0);
        check("rst_tdo", tdo, 1'b0);
        check("rst_strobes", {dr_cap, dr_shf, dr_upd, ir_upd}, 4'b0000);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        check("tlr_after5", tlr, 1'b1);
        check("ir_after5", ir_value, RST_IR);
        check("tdo_en_after5", tdo_en, 1'b0);
        model_ir = RST_IR;
    endtask

    task automatic goto_rti();
        tick(1'b0, 1'b0);
        check("rti_not_tlr", tlr, 1'b0);
    endtask

    task automatic shift_ir(input logic [7:0] val, input int nbits);
        logic [7:0] sh;
        logic       b;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("capir_tdo_en", tdo_en, 1'b0);
        tick(1'b0, 1'b0);
        check("shfir_tdo_en", tdo_en, 1'b1);
        sh = 8'h01;
        for (int i = 0; i < nbits; i++) begin
            b = val[i % 8];
            check("ir_tdo", tdo, sh[0]);
            tick((i == nbits - 1) ? 1'b1 : 1'b0, b);
            sh = {b, sh[7:1]};
        end
        check("ex1ir_tdo_en", tdo_en, 1'b0);
        check("ex1ir_ir_upd", ir_upd, 1'b0);
        tick(1'b1, 1'b0);
        check("updir_ir_upd", ir_upd, 1'b1);
        check("updir_ir_hold", ir_value, model_ir);
        tick(1'b0, 1'b0);
        check("rti_ir_upd", ir_upd, 1'b0);
        check("ir_value", ir_value, sh);
        model_ir = sh;
    endtask

    task automatic shift_dr(input int n, input bit use_pat, input logic [31:0] pat);
        bit   q[$];
        int   k;
        logic b, e, exp;
        k = dr_kind(model_ir);
        if (k == 1) q.push_back(1'b0);
        if (k == 2) for (int j = 0; j < 32; j++) q.push_back(IDV[j]);
        tick(1'b1, 1'b0);
        check("seldr_cap", dr_cap, 1'b0);
        tick(1'b0, 1'b0);
        check("capdr_cap", dr_cap, (k == 0));
        check("capdr_tdo_en", tdo_en, 1'b0);
        tick(1'b0, 1'b0);
        check("shfdr_cap_off", dr_cap, 1'b0);
        for (int i = 0; i < n; i++) begin
            b = use_pat ? pat[i] : 1'($urandom_range(0, 1));
            e = 1'($urandom_range(0, 1));
            ext_tdo = e;
            #1;
            if (k == 0) begin
                exp = e;
            end else begin
                exp = q.pop_front();
                q.push_back(b);
            end
            check("dr_tdo", tdo, exp);
            check("dr_shift", dr_shf, (k == 0));
            check("dr_tdo_en", tdo_en, 1'b1);
            tick((i == n - 1) ? 1'b1 : 1'b0, b);
        end
        check("ex1dr_tdo_en", tdo_en, 1'b0);
        check("ex1dr_shift", dr_shf, 1'b0);
        check("ex1dr_tdo", tdo, 1'b0);
        tick(1'b1, 1'b0);
        check("upddr_upd", dr_upd, (k == 0));
        tick(1'b0, 1'b0);
        check("rti_dr_upd", dr_upd, 1'b0);
    endtask

    initial begin
        logic [7:0] v;
        trst = 1'b0; tms = 1'b1; tdi = 1'b0; tap_en = 1'b1; ext_tdo = 1'b0;
        model_ir = RST_IR;

        reset_tap();
        goto_rti();
        // reset instruction readout: IDCODE or bypass depending on build
        shift_dr(40, 1'b0, 32'h0);

        shift_ir(8'hFF, 8);
        shift_dr(3, 1'b1, 32'h0000_0005);

        shift_ir(8'h10, 8);
        shift_dr(4, 1'b0, 32'h0);

        shift_ir(8'h01, 8);
        shift_dr(34, 1'b0, 32'h0);

        for (int r = 0; r < 8; r++) begin
            v = 8'($urandom);
            shift_ir(v, $urandom_range(6, 10));
            shift_dr($urandom_range(1, 12), 1'b0, 32'h0);
        end

        // reset in the middle of an IR shift
        shift_ir(8'h10, 8);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'($urandom_range(0, 1)));
        trst = 1'b1;
        tick(1'b1, 1'b0);
        trst = 1'b0;
        check("mid_rst_tlr", tlr, 1'b1);
        check("mid_rst_ir_upd", ir_upd, 1'b0);
        check("mid_rst_tdo_en", tdo_en, 1'b0);
        check("mid_rst_ir", ir_value, RST_IR);
        tick(1'b1, 1'b0);
        check("mid_rst_ir_upd2", ir_upd, 1'b0);
        check("mid_rst_tlr2", tlr, 1'b1);
        model_ir = RST_IR;

        // TAP disable in the middle of a DR shift
        goto_rti();
        shift_ir(8'h3C, 8);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("dis_pre_tdo_en", tdo_en, 1'b1);
        tap_en = 1'b0;
        tick(1'b0, 1'b0);
        check("dis_tlr", tlr, 1'b1);
        check("dis_tdo_en", tdo_en, 1'b0);
        check("dis_shift", dr_shf, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check("dis_hold_tlr", tlr, 1'b1);
            check("dis_hold_tdo", tdo, 1'b0);
        end
        check("dis_ir", ir_value, RST_IR);
        tap_en = 1'b1;
        model_ir = RST_IR;

        // random TMS walks, then five TMS=1 must land in TLR
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 25; i++) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
            check("walk_tlr", tlr, 1'b1);
            check("walk_tdo_en", tdo_en, 1'b0);
            tick(1'b1, 1'b0);
            check("walk_ir", ir_value, RST_IR);
        end
        model_ir = RST_IR;

        goto_rti();
        shift_dr(6, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ct_had_tap_ctrl.md
CT_HAD_TAP_CTRL -- requirements
Module: ct_had_tap_ctrl

Interface
REQ-001 The block SHALL expose parameter IDCODE_VAL, default 32'h1000_0B6F, meaning the constant captured into the IDCODE data register.
REQ-002 The block SHALL have one clock, `tclk`, and one reset, `trst`; the reset SHALL be synchronous and active-high.
REQ-003 The block SHALL have the following ports, each given as name, direction, width, meaning:
- tclk, in, 1: JTAG clock; all state changes on its rising edge.
- trst, in, 1: synchronous active-high reset.
- pad_had_jtg_tms, in, 1: TMS sampled on each rising edge.
- io_serial_tdi, in, 1: TDI after the IO block.
- io_sm_tap_en, in, 1: TAP enable; when low, the FSM holds in TLR.
- ext_dr_tdo, in, 1: serial output of the external (non-IDCODE, non-BYPASS) data register.
- sm_io_tdo_en, out, 1: TDO drive enable.
- sm_serial_tdo, out, 1: TDO data.
- sm_ir_value, out, 8: current instruction.
- sm_dr_capture, out, 1: one-cycle external-DR capture strobe.
- sm_dr_shift, out, 1: external-DR shift strobe.
- sm_dr_update, out, 1: one-cycle external-DR update strobe.
- sm_ir_update, out, 1: one-cycle IR update strobe.
- sm_tlr, out, 1: FSM is in Test-Logic-Reset.

Function
REQ-004 The block SHALL implement the 16-state IEEE 1149.1 TAP FSM:
- States: TLR, RTI, SEL_DR, CAP_DR, SHF_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SHF_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR.
- The FSM advances once per tclk, following the standard TMS-driven transitions.
REQ-005 Five consecutive cycles with TMS=1 SHALL reach TLR from any state.
REQ-006 While io_sm_tap_en=0, the next state SHALL be TLR regardless of TMS.
REQ-007 In CAP_IR, ir_shift SHALL load 8'b0000_0001.
REQ-008 In SHF_IR, ir_shift SHALL load {io_serial_tdi, ir_shift[7:1]}.
REQ-009 In UPD_IR, sm_ir_value SHALL load ir_shift on that edge, and sm_ir_update SHALL be 1 for that one cycle.
REQ-010 In TLR, sm_ir_value SHALL be forced to the reset instruction (see REQ-021/REQ-022).
REQ-011 Instruction decode SHALL be:
- 8'h01 selects IDCODE.
- 8'hFF selects BYPASS.
- All other values select the external DR.
REQ-012 For BYPASS, the 1-bit bypass register SHALL:
- clear in CAP_DR;
- load io_serial_tdi in SHF_DR.
REQ-013 For IDCODE, the 32-bit register SHALL:
- load IDCODE_VAL in CAP_DR;
- shift right with io_serial_tdi entering at bit 31 in SHF_DR.
REQ-014 sm_dr_capture, sm_dr_shift and sm_dr_update SHALL be 1 only while the state is CAP_DR, SHF_DR or UPD_DR respectively, and only when the external DR is selected.
REQ-015 sm_serial_tdo SHALL be selected combinationally from registers only:
- In SHF_IR: ir_shift[0].
- In SHF_DR: the selected DR's bit 0 (bypass register, IDCODE register bit 0, or ext_dr_tdo).
- Otherwise: 0.
REQ-016 sm_io_tdo_en SHALL be a flop, set to 1 exactly when the next state is SHF_IR or SHF_DR, so that it is high in the same cycles as those states.
REQ-017 sm_tlr SHALL equal (state==TLR).
REQ-018 If IR shift ends after fewer than 8 or more than 8 cycles, UPD_IR SHALL load whatever ir_shift holds, with no error flag.

Reset
REQ-019 While trst=1 at a rising edge, the block SHALL:
- set state to TLR;
- set sm_ir_value to the reset instruction;
- clear ir_shift, the bypass register and the IDCODE register;
- set sm_io_tdo_en=0.
After reset, all strobes are 0, sm_serial_tdo=0 and sm_tlr=1.
REQ-020 When reset is asserted mid-shift, it SHALL discard the shift in progress without generating an update strobe.

Configuration
REQ-021 With macro HAD_TAP_IDCODE_EN defined:
- the IDCODE register SHALL exist;
- the reset instruction SHALL be 8'h01.
REQ-022 Without HAD_TAP_IDCODE_EN:
- the IDCODE register SHALL be absent;
- 8'h01 SHALL decode as BYPASS;
- the reset instruction SHALL be 8'hFF.

Structure
REQ-023 A shared package SHALL hold:
- the TAP state encoding (4-bit, 16 named constants);
- instruction constants INSTR_IDCODE=8'h01 and INSTR_BYPASS=8'hFF;
- the default IDCODE constant.
REQ-024 The FSM (state register and next-state logic) SHALL be a sub-module named ct_had_tap_fsm; the IR, DR and TDO logic SHALL remain in ct_had_tap_ctrl.

Verification
REQ-025 Reset state with HAD_TAP_IDCODE_EN defined: trst=1 for 1 cycle, then 5 cycles of TMS=1 -> sm_tlr=1, sm_ir_value=8'h01, sm_io_tdo_en=0.
REQ-026 IDCODE readout with HAD_TAP_IDCODE_EN defined: from RTI, TMS sequence 1,0,0, then 32 shift cycles -> sm_serial_tdo yields IDCODE_VAL LSB first, and sm_io_tdo_en=1 only during SHF_DR.
REQ-027 IR load: shift 8'hFF into the IR, then pass UPD_IR -> sm_ir_update is a single-cycle pulse and sm_ir_value=8'hFF. A following DR shift of TDI pattern 1,0,1 returns 0,1,0 (one-cycle bypass delay, leading 0).
REQ-028 External DR: load IR 8'h10, then capture/shift 4 cycles/update -> sm_dr_capture is 1 cycle, sm_dr_shift is 4 cycles, sm_dr_update is 1 cycle, and sm_serial_tdo follows ext_dr_tdo.
REQ-029 Reset and disable mid-operation:
- Assert trst during SHF_IR -> next cycle TLR, no sm_ir_update.
- Drive io_sm_tap_en=0 in SHF_DR -> next cycle TLR, sm_io_tdo_en=0.
REQ-030 Build without HAD_TAP_IDCODE_EN: reset -> sm_ir_value=8'hFF; load 8'h01 and shift DR -> bypass behaviour.
